// File: rtl/memory_unload.sv
// Parallel-to-serial unloader: captures a K-word array in one cycle and streams
// the words out on a valid/ready interface, word 0 first. All state moves on negedge clk.
module memory_unload #(
  parameter int N = 23,
  parameter int M = 8,
  parameter int L = N + M + 1,
  parameter int K = 16
) (
  input  logic                   clk,
  input  logic                   reset_unload,
  input  logic                   start_unload,
  input  logic [L*K-1:0]         Arr_in,
  input  logic                   ready_out,
  output logic [L-1:0]           out,
  output logic                   valid_out,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(K)-1:0]   index
);

  localparam int IW = $clog2(K);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  // Handshake: a word moves on a negedge where valid_out=1 and ready_out=1;
  // while ready_out=0, out/index/valid_out hold so nothing is dropped or repeated.
  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

  state_t          state, state_n;
  logic [L-1:0]    shadow [K];
  logic [L-1:0]    out_n;
  logic [IW-1:0]   index_n;
  logic [IW-1:0]   index_inc;
  logic            valid_n, busy_n, done_n, load;

  assign index_inc = index + 1'b1;

  always_comb begin
    state_n = state;
    out_n   = out;
    index_n = index;
    valid_n = valid_out;
    busy_n  = busy;
    done_n  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        out_n   = '0;
        index_n = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (start_unload) begin
          load    = 1'b1;
          out_n   = Arr_in[L-1:0];
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (ready_out) begin
          if (index == LAST) begin
            // Last word accepted: out returns to 0 alongside valid_out.
            out_n   = '0;
            index_n = '0;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = FINISH;
          end else begin
            index_n = index_inc;
            out_n   = shadow[index_inc];
          end
        end
      end
      FINISH: begin
        out_n   = '0;
        index_n = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!reset_unload) begin
      state     <= IDLE;
      out       <= '0;
      index     <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      index     <= index_n;
      valid_out <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Shadow copy decouples the stream from later changes on Arr_in.
  always_ff @(negedge clk) begin
    if (!reset_unload) begin
      for (int i = 0; i < K; i++) shadow[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < K; i++) shadow[i] <= Arr_in[i*L +: L];
    end
  end

endmodule

// File: tb/tb_memory_unload.sv
// Directed bench for memory_unload: a small K=4/L=8 instance and a default K=16/L=32
// instance, checked through an expected-word scoreboard plus directed status checks.
module tb_memory_unload;

  logic         clk;
  logic         rst_n;

  logic         start_s, rdy_s;
  logic [31:0]  arr_s;
  logic [7:0]   out_s;
  logic         valid_s, busy_s, done_s;
  logic [1:0]   idx_s;

  logic         start_d, rdy_d;
  logic [511:0] arr_d;
  logic [31:0]  out_d;
  logic         valid_d, busy_d, done_d;
  logic [3:0]   idx_d;

  logic [7:0]   exp_s_q[$];
  logic [1:0]   exp_si_q[$];
  logic [31:0]  exp_d_q[$];
  logic [3:0]   exp_di_q[$];

  int tests = 0;
  int fails = 0;
  int done_cnt_s = 0;
  int done_cnt_d = 0;

  memory_unload #(.N(4), .M(3), .K(4)) dut_s (
    .clk(clk), .reset_unload(rst_n), .start_unload(start_s), .Arr_in(arr_s),
    .ready_out(rdy_s), .out(out_s), .valid_out(valid_s), .busy(busy_s),
    .done(done_s), .index(idx_s)
  );

  memory_unload dut_d (
    .clk(clk), .reset_unload(rst_n), .start_unload(start_d), .Arr_in(arr_d),
    .ready_out(rdy_d), .out(out_d), .valid_out(valid_d), .busy(busy_d),
    .done(done_d), .index(idx_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge with inputs already set: a word visible now is consumed at the coming negedge.
  task automatic cyc();
    logic [7:0]  ws;
    logic [1:0]  is;
    logic [31:0] wd;
    logic [3:0]  id;
    if (done_s === 1'b1) done_cnt_s++;
    if (done_d === 1'b1) done_cnt_d++;
    if (rst_n && valid_s === 1'b1 && rdy_s) begin
      tests++;
      assert (exp_s_q.size() != 0) else begin
        fails++;
        $error("FAIL s_extra_word: observed %0h expected none", out_s);
      end
      if (exp_s_q.size() != 0) begin
        ws = exp_s_q.pop_front();
        is = exp_si_q.pop_front();
        chk("s_word", 64'(out_s), 64'(ws));
        chk("s_index", 64'(idx_s), 64'(is));
      end
    end
    if (rst_n && valid_d === 1'b1 && rdy_d) begin
      tests++;
      assert (exp_d_q.size() != 0) else begin
        fails++;
        $error("FAIL d_extra_word: observed %0h expected none", out_d);
      end
      if (exp_d_q.size() != 0) begin
        wd = exp_d_q.pop_front();
        id = exp_di_q.pop_front();
        chk("d_word", 64'(out_d), 64'(wd));
        chk("d_index", 64'(idx_d), 64'(id));
      end
    end
    @(posedge clk);
  endtask

  task automatic push_s(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      exp_s_q.push_back(a[i*8 +: 8]);
      exp_si_q.push_back(2'(i));
    end
  endtask

  task automatic push_d();
    for (int i = 0; i < 16; i++) begin
      exp_d_q.push_back(32'(i + 1));
      exp_di_q.push_back(4'(i));
    end
  endtask

  task automatic chk_idle_s(input string tag);
    chk({tag, "_valid"}, 64'(valid_s), 64'(0));
    chk({tag, "_busy"}, 64'(busy_s), 64'(0));
    chk({tag, "_out"}, 64'(out_s), 64'(0));
    chk({tag, "_index"}, 64'(idx_s), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; start_s = 1'b0; rdy_s = 1'b0; arr_s = '0;
    start_d = 1'b0; rdy_d = 1'b0; arr_d = '0;
    repeat (3) cyc();
    chk_idle_s("reset");
    chk("reset_done", 64'(done_s), 64'(0));
    chk("reset_d_valid", 64'(valid_d), 64'(0));
    rst_n = 1'b1;
    cyc();

    // Basic stream with ready held high
    arr_s = 32'h4433_2211; push_s(arr_s);
    start_s = 1'b1; rdy_s = 1'b1;
    cyc();
    start_s = 1'b0;
    chk("basic_first_valid", 64'(valid_s), 64'(1));
    chk("basic_first_out", 64'(out_s), 64'(8'h11));
    chk("basic_busy", 64'(busy_s), 64'(1));
    repeat (4) cyc();
    chk("basic_done", 64'(done_s), 64'(1));
    chk("basic_busy_fall", 64'(busy_s), 64'(0));
    chk("basic_valid_fall", 64'(valid_s), 64'(0));
    chk("basic_out_clear", 64'(out_s), 64'(0));
    chk("basic_drained", 64'(exp_s_q.size()), 64'(0));
    cyc();
    chk("basic_done_one_cycle", 64'(done_s), 64'(0));

    // Backpressure while word 1 is presented
    push_s(arr_s);
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    cyc();
    rdy_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_out", 64'(out_s), 64'(8'h22));
      chk("bp_hold_index", 64'(idx_s), 64'(1));
      chk("bp_hold_valid", 64'(valid_s), 64'(1));
      cyc();
    end
    rdy_s = 1'b1;
    repeat (3) cyc();
    chk("bp_done", 64'(done_s), 64'(1));
    chk("bp_drained", 64'(exp_s_q.size()), 64'(0));
    cyc();

    // Reload request during SEND and FINISH is ignored
    push_s(arr_s);
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    cyc();
    arr_s = 32'hDDCC_BBAA; start_s = 1'b1;
    repeat (3) cyc();
    chk("reload_done", 64'(done_s), 64'(1));
    chk("reload_drained", 64'(exp_s_q.size()), 64'(0));
    cyc();
    start_s = 1'b0;
    chk_idle_s("reload_finish_ignored");
    push_s(arr_s);
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    chk("reload_new_first", 64'(out_s), 64'(8'hAA));
    repeat (4) cyc();
    chk("reload_new_drained", 64'(exp_s_q.size()), 64'(0));
    cyc();

    // Reset in the middle of a transfer
    arr_s = 32'h4433_2211; push_s(arr_s);
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    cyc();
    rst_n = 1'b0;
    exp_s_q.delete(); exp_si_q.delete();
    cyc();
    rst_n = 1'b1;
    chk_idle_s("midreset");
    chk("midreset_done", 64'(done_s), 64'(0));
    push_s(arr_s);
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    chk("midreset_restart_index", 64'(idx_s), 64'(0));
    repeat (4) cyc();
    chk("midreset_drained", 64'(exp_s_q.size()), 64'(0));
    cyc();

    // Idle with ready toggling
    for (int i = 0; i < 8; i++) begin
      rdy_s = 1'($urandom_range(0, 1));
      cyc();
      chk("idle_valid", 64'(valid_s), 64'(0));
      chk("idle_out", 64'(out_s), 64'(0));
      chk("idle_done", 64'(done_s), 64'(0));
    end
    chk("s_done_count", 64'(done_cnt_s), 64'(5));

    // Default instance: two arrays back to back
    for (int i = 0; i < 16; i++) arr_d[i*32 +: 32] = 32'(i + 1);
    push_d(); push_d();
    start_d = 1'b1; rdy_d = 1'b1;
    cyc();
    start_d = 1'b0;
    repeat (16) cyc();
    chk("d_done1", 64'(done_d), 64'(1));
    cyc();
    start_d = 1'b1;
    cyc();
    start_d = 1'b0;
    chk("d_second_start", 64'(out_d), 64'(1));
    for (int b = 0; b < 200 && exp_d_q.size() > 0; b++) begin
      rdy_d = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("d_drained", 64'(exp_d_q.size()), 64'(0));
    chk("d_done2", 64'(done_d), 64'(1));
    rdy_d = 1'b1;
    cyc();
    cyc();
    chk("d_done_count", 64'(done_cnt_d), 64'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
